// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage; drives the PC and holds a redirect that arrives during a stall
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          CNT_W    = 32,
  parameter int          STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);
  logic        pc_stop;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        unused_stall;
  assign pc_stop = stall[0];
  assign {br_e, br_addr} = br_bus;
  assign unused_stall = ^stall[STALL_W-1:1];
  assign if_to_id_bus = {ce_r, pc_r};
  assign inst_sram_en = ce_r;
  assign inst_sram_addr = pc_r;
  assign inst_sram_wen = 4'b0;
  assign inst_sram_wdata = 32'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
      ce_r <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr <= 32'b0;
      fetch_cnt <= '0;
      redirect_cnt <= '0;
    end else if (!pc_stop) begin
      if (!ce_r) begin
        ce_r <= 1'b1;
        pc_r <= RESET_PC + 32'd4;
      end else begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
        pc_r <= pend_valid ? pend_addr : br_e ? br_addr : pc_r + 32'd4;
        pend_valid <= 1'b0;
        if (pend_valid || br_e) redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end else if (ce_r && !pend_valid && br_e) begin
      pend_valid <= 1'b1;
      pend_addr <= br_addr;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage against a behavioural fetch model
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [32:0] br_bus = '0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [3:0]  fetch_cnt;
  logic [3:0]  redirect_cnt;
  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic [3:0]  fc;
    logic [3:0]  rc;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  bit          m_ce;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_fc;
  int          m_rc;
  if_stage #(.RESET_PC(RESET_PC), .CNT_W(4), .STALL_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus),
    .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .fetch_cnt(fetch_cnt),
    .redirect_cnt(redirect_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] a);
    @(negedge clk);
    rst = r;
    stall = {5'($urandom), s};
    br_bus = {b, a};
    if (r) begin
      m_ce = 0;
      m_pc = RESET_PC;
      m_pend = 0;
      m_tgt = 32'b0;
      m_fc = 0;
      m_rc = 0;
    end else if (s) begin
      if (m_ce && !m_pend && b) begin
        m_pend = 1;
        m_tgt = a;
      end
    end else if (!m_ce) begin
      m_ce = 1;
      m_pc = 32'hBFC0_0000;
    end else begin
      m_fc++;
      if (m_pend) begin
        m_pc = m_tgt;
        m_pend = 0;
        m_rc++;
      end else if (b) begin
        m_pc = a;
        m_rc++;
      end else m_pc = m_pc + 32'd4;
    end
    sb.push_back('{m_ce, m_pc, 4'(m_fc % 16), 4'(m_rc % 16)});
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("bus", 64'(if_to_id_bus), 64'({e.ce, e.pc}));
        chk("sram_en", 64'(inst_sram_en), 64'(e.ce));
        chk("sram_addr", 64'(inst_sram_addr), 64'(e.pc));
        chk("sram_wen", 64'(inst_sram_wen), 64'd0);
        chk("sram_wdata", 64'(inst_sram_wdata), 64'd0);
        chk("fetch_cnt", 64'(fetch_cnt), 64'(e.fc));
        chk("redirect_cnt", 64'(redirect_cnt), 64'(e.rc));
      end
    end
  end
  initial begin
    repeat (3) step(1, 0, 0, 32'h0);
    step(0, 0, 1, 32'h1111_1110);
    repeat (2) step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'hBFC0_0100);
    step(0, 1, 1, 32'h8000_1000);
    step(0, 1, 1, 32'h8000_2000);
    step(0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h1234_5678);
    step(0, 1, 0, 32'h0);
    step(0, 0, 1, 32'h0BAD_0000);
    step(0, 1, 1, 32'h1234_5678);
    step(1, 0, 0, 32'h0);
    repeat (2) step(0, 0, 0, 32'h0);
    repeat (17) step(0, 0, 0, 32'h0);
    repeat (3) step(0, 1, 0, 32'h0);
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) step(0, 0, 0, 32'h0);
    repeat (800) step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
                      $urandom_range(0, 99) < 30, $urandom);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
